// File: rtl/lfsr_pkg.sv
// Definitions shared by the PRBS generator (lfsr) and the receive-side checker (lfsr_checker).
// Both ends must agree on the register width and the feedback taps.
package lfsr_pkg;

    localparam int LFSR_W = 16;

    // x^16+x^14+x^13+x^11+1 expressed on history bits [0,2,3,5], bit 0 oldest
    localparam logic [LFSR_W-1:0] TAPS_DEFAULT = 16'h002D;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic lfsr_pred(input logic [LFSR_W-1:0] hist, input logic [LFSR_W-1:0] taps);
        return ^(hist & taps);
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Bit-stream input and status/counter outputs of the PRBS checker.
// The source side (bit feeder) uses master; the checker uses slave.
interface lfsr_checker_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_bit;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_bit, clear_cnt,
        input  locked, err_pulse, bit_count, err_count
    );

    modport slave (
        input  in_valid, in_bit, clear_cnt,
        output locked, err_pulse, bit_count, err_count
    );
endinterface

// File: rtl/lfsr_checker_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; a synchronous clear
// takes priority over a simultaneous increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: loads 16 received bits, verifies the LFSR prediction,
// then flywheels on its own prediction while counting checked bits and mismatches.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS      = TAPS_DEFAULT,
    parameter int                SYNC_GOOD = 32,
    parameter int                LOSS_ERRS = 8,
    parameter int                LOSS_WIN  = 256,
    parameter int                CNT_W     = 32
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_checker_if.slave bus
);
    localparam int FILL_W = $clog2(LFSR_W);
    localparam int GOOD_W = $clog2(SYNC_GOOD + 1);
    localparam int WIN_W  = $clog2(LOSS_WIN + 1);
    localparam int ERR_W  = $clog2(LOSS_ERRS + 1);

    state_t            state_reg, state_next;
    logic [LFSR_W-1:0] hist_reg, hist_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [GOOD_W-1:0] good_reg, good_next;
    logic [WIN_W-1:0]  win_reg, win_next;
    logic [ERR_W-1:0]  win_err_reg, win_err_next;
    logic              locked_reg, locked_next;
    logic              pulse_reg, pulse_next;

    logic              pred;
    logic              mismatch;
    logic [LFSR_W-1:0] shift_in;
    logic [LFSR_W-1:0] shift_fly;
    logic [GOOD_W-1:0] good_inc;
    logic [WIN_W-1:0]  win_inc;
    logic [ERR_W-1:0]  win_err_sum;
    logic [1:0]        cnt_inc;
    logic [CNT_W-1:0]  cnt_val [2];

    assign pred        = lfsr_pred(hist_reg, TAPS);
    assign mismatch    = bus.in_bit ^ pred;
    assign shift_in    = {bus.in_bit, hist_reg[LFSR_W-1:1]};
    assign shift_fly   = {pred, hist_reg[LFSR_W-1:1]};
    assign good_inc    = good_reg + 1'b1;
    assign win_inc     = win_reg + 1'b1;
    assign win_err_sum = win_err_reg + {{(ERR_W-1){1'b0}}, mismatch};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= HUNT;
            hist_reg    <= '0;
            fill_reg    <= '0;
            good_reg    <= '0;
            win_reg     <= '0;
            win_err_reg <= '0;
            locked_reg  <= 1'b0;
            pulse_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            good_reg    <= good_next;
            win_reg     <= win_next;
            win_err_reg <= win_err_next;
            locked_reg  <= locked_next;
            pulse_reg   <= pulse_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        good_next    = good_reg;
        win_next     = win_reg;
        win_err_next = win_err_reg;
        pulse_next   = 1'b0;
        cnt_inc      = 2'b00;

        if (bus.in_valid) begin
            unique case (state_reg)
                HUNT: begin
                    hist_next = shift_in;
                    if (fill_reg == FILL_W'(LFSR_W - 1)) begin
                        state_next = VERIFY;
                        fill_next  = '0;
                        good_next  = '0;
                    end else begin
                        fill_next = fill_reg + 1'b1;
                    end
                end
                VERIFY: begin
                    hist_next = shift_in;
                    good_next = mismatch ? '0 : good_inc;
                    // An all-zero history is the LFSR lock-up state and can never be a valid sequence
                    if (shift_in == '0) begin
                        state_next = HUNT;
                        fill_next  = '0;
                    end else if (!mismatch && (good_inc == GOOD_W'(SYNC_GOOD))) begin
                        state_next   = LOCKED;
                        win_next     = '0;
                        win_err_next = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a single line error is counted only once
                    hist_next  = shift_fly;
                    cnt_inc    = {mismatch, 1'b1};
                    pulse_next = mismatch;
                    if (win_err_sum == ERR_W'(LOSS_ERRS)) begin
                        state_next   = HUNT;
                        fill_next    = '0;
                        win_next     = '0;
                        win_err_next = '0;
                    end else if (win_inc == WIN_W'(LOSS_WIN)) begin
                        win_next     = '0;
                        win_err_next = '0;
                    end else begin
                        win_next     = win_inc;
                        win_err_next = win_err_sum;
                    end
                end
                default: begin
                    state_next = HUNT;
                    fill_next  = '0;
                end
            endcase
        end

        // Rises one edge after entering LOCKED, falls on the very edge that leaves it
        locked_next = (state_reg == LOCKED) && (state_next == LOCKED);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (cnt_inc[gi]),
                .clr   (bus.clear_cnt),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.bit_count = cnt_val[0];
    assign bus.err_count = cnt_val[1];
    assign bus.locked    = locked_reg;
    assign bus.err_pulse = pulse_reg;
endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a 16-bit Fibonacci generator feeds the checker, with random bit
// inversions, valid gaps and clears; a queue-based behavioural model supplies expected outputs.
module tb_lfsr_checker;
    import lfsr_pkg::*;

    localparam int SYNC_GOOD = 32;
    localparam int LOSS_ERRS = 8;
    localparam int LOSS_WIN  = 256;
    localparam int CNT_W     = 32;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    lfsr_checker_if #(.CNT_W(CNT_W)) bus ();

    lfsr_checker #(
        .TAPS      (16'h002D),
        .SYNC_GOOD (SYNC_GOOD),
        .LOSS_ERRS (LOSS_ERRS),
        .LOSS_WIN  (LOSS_WIN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] gen_state;
    bit          err_mask [512];

    // Behavioural model: last 16 received/predicted bits, oldest at index 0
    bit     mq[$];
    int     m_mode;  // 0 hunting, 1 verifying, 2 locked
    int     m_fill, m_good, m_win, m_werr;
    bit     m_locked, m_pulse;
    longint m_bc, m_ec;

    function automatic bit gen_next();
        bit b;
        b = gen_state[0];
        gen_state = {gen_state[0] ^ gen_state[2] ^ gen_state[3] ^ gen_state[5], gen_state[15:1]};
        return b;
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) mq.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_good = 0; m_win = 0; m_werr = 0;
        m_locked = 1'b0; m_pulse = 1'b0; m_bc = 0; m_ec = 0;
    endfunction

    function automatic void model_push(input bit x);
        mq.push_back(x);
        void'(mq.pop_front());
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit c);
        int prev;
        bit p;
        bit zero;
        prev    = m_mode;
        m_pulse = 1'b0;
        if (v) begin
            p = mq[0] ^ mq[2] ^ mq[3] ^ mq[5];
            if (m_mode == 0) begin
                model_push(b);
                m_fill++;
                if (m_fill == 16) begin m_mode = 1; m_good = 0; end
            end else if (m_mode == 1) begin
                model_push(b);
                m_good = (b == p) ? m_good + 1 : 0;
                zero = 1'b1;
                foreach (mq[i]) if (mq[i]) zero = 1'b0;
                if (zero) begin
                    m_mode = 0; m_fill = 0;
                end else if (m_good == SYNC_GOOD) begin
                    m_mode = 2; m_win = 0; m_werr = 0;
                end
            end else begin
                model_push(p);
                if (m_bc < CNT_MAX) m_bc++;
                if (b != p) begin
                    if (m_ec < CNT_MAX) m_ec++;
                    m_pulse = 1'b1;
                    m_werr++;
                end
                m_win++;
                if (m_werr == LOSS_ERRS) begin
                    m_mode = 0; m_fill = 0; m_win = 0; m_werr = 0;
                end else if (m_win == LOSS_WIN) begin
                    m_win = 0; m_werr = 0;
                end
            end
        end
        m_locked = (prev == 2) && (m_mode == 2);
        if (c) begin m_bc = 0; m_ec = 0; end
    endfunction

    task automatic drive(input bit v, input bit b, input bit c);
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.clear_cnt = c;
        @(posedge clk);
        #1;
        model_step(v, b, c);
    endtask

    function automatic void pick_errors(input int lo, input int hi, input int n);
        int placed = 0;
        int p;
        while (placed < n) begin
            p = int'($urandom_range(hi, lo));
            if (!err_mask[p]) begin err_mask[p] = 1'b1; placed++; end
        end
    endfunction

    function automatic void clear_mask();
        foreach (err_mask[i]) err_mask[i] = 1'b0;
    endfunction

    task automatic hard_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clear_cnt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic align_window();
        for (int i = 0; i < LOSS_WIN && m_win != 0; i++) drive(1'b1, gen_next(), 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clear_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", bus.locked); end
        checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b want 0", bus.err_pulse); end
        checks++; if (bus.bit_count !== '0) begin errors++; $display("FAIL reset_bits: got %0d want 0", bus.bit_count); end
        checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL reset_errs: got %0d want 0", bus.err_count); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_clean_lock();
        gen_state = 16'hACE1;
        for (int n = 1; n <= 1048; n++) begin
            drive(1'b1, gen_next(), 1'b0);
            checks++; if (bus.locked !== m_locked) begin errors++; $display("FAIL clean_locked bit %0d: got %0b want %0b", n, bus.locked, m_locked); end
            checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL clean_pulse bit %0d: got %0b want 0", n, bus.err_pulse); end
            if (n == 48) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL clean_lock_early: got %0b want 0", bus.locked); end
            end
            if (n == 49) begin
                checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL clean_lock_at48: got %0b want 1", bus.locked); end
            end
        end
        checks++; if (bus.bit_count !== 32'd1000) begin errors++; $display("FAIL clean_bits: got %0d want 1000", bus.bit_count); end
        checks++; if (bus.err_count !== 32'd0) begin errors++; $display("FAIL clean_errs: got %0d want 0", bus.err_count); end
        $display("test_clean_lock done: bits=%0d errs=%0d", bus.bit_count, bus.err_count);
    endtask

    task automatic test_single_error();
        int pos = int'($urandom_range(89, 10));
        int pulses = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, gen_next() ^ (i == pos), 1'b0);
            if (bus.err_pulse === 1'b1) pulses++;
            checks++; if (bus.err_pulse !== m_pulse) begin errors++; $display("FAIL single_pulse bit %0d: got %0b want %0b", i, bus.err_pulse, m_pulse); end
            checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL single_locked bit %0d: got %0b want 1", i, bus.locked); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulse_count: got %0d want 1", pulses); end
        checks++; if (bus.err_count !== 32'd1) begin errors++; $display("FAIL single_errs: got %0d want 1", bus.err_count); end
        checks++; if (bus.bit_count !== m_bc[31:0]) begin errors++; $display("FAIL single_bits: got %0d want %0d", bus.bit_count, m_bc); end
        $display("test_single_error done: pos=%0d errs=%0d", pos, bus.err_count);
    endtask

    task automatic test_burst_loss();
        int last = 0;
        drive(1'b0, 1'b0, 1'b1);
        align_window();
        clear_mask();
        pick_errors(0, 99, LOSS_ERRS);
        for (int i = 0; i < 100; i++) if (err_mask[i]) last = i;
        for (int i = 0; i <= last; i++) begin
            drive(1'b1, gen_next() ^ err_mask[i], 1'b0);
            checks++; if (bus.err_pulse !== err_mask[i]) begin errors++; $display("FAIL burst_pulse bit %0d: got %0b want %0b", i, bus.err_pulse, err_mask[i]); end
            checks++; if (bus.locked !== (i < last)) begin errors++; $display("FAIL burst_locked bit %0d: got %0b want %0b", i, bus.locked, i < last); end
        end
        checks++; if (bus.err_count !== 32'd8) begin errors++; $display("FAIL burst_errs: got %0d want 8", bus.err_count); end
        for (int n = 1; n <= 49; n++) begin
            drive(1'b1, gen_next(), 1'b0);
            checks++; if (bus.locked !== m_locked) begin errors++; $display("FAIL relock_model bit %0d: got %0b want %0b", n, bus.locked, m_locked); end
            if (n == 48) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %0b want 0", bus.locked); end
            end
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL relock_at48: got %0b want 1", bus.locked); end
        $display("test_burst_loss done: last_err=%0d", last);
    endtask

    task automatic test_two_windows();
        drive(1'b0, 1'b0, 1'b1);
        align_window();
        drive(1'b0, 1'b0, 1'b1);
        clear_mask();
        pick_errors(0, LOSS_WIN - 1, LOSS_ERRS - 1);
        pick_errors(LOSS_WIN, 2 * LOSS_WIN - 1, LOSS_ERRS - 1);
        for (int i = 0; i < 2 * LOSS_WIN; i++) begin
            drive(1'b1, gen_next() ^ err_mask[i], 1'b0);
            checks++; if (bus.err_pulse !== err_mask[i]) begin errors++; $display("FAIL win_pulse bit %0d: got %0b want %0b", i, bus.err_pulse, err_mask[i]); end
            checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL win_locked bit %0d: got %0b want 1", i, bus.locked); end
        end
        checks++; if (bus.err_count !== 32'd14) begin errors++; $display("FAIL win_errs: got %0d want 14", bus.err_count); end
        checks++; if (bus.bit_count !== 32'd512) begin errors++; $display("FAIL win_bits: got %0d want 512", bus.bit_count); end
        $display("test_two_windows done: errs=%0d", bus.err_count);
    endtask

    task automatic test_loss_at_window_end();
        align_window();
        clear_mask();
        pick_errors(0, LOSS_WIN - 2, LOSS_ERRS - 1);
        err_mask[LOSS_WIN - 1] = 1'b1;
        for (int i = 0; i < LOSS_WIN; i++) begin
            drive(1'b1, gen_next() ^ err_mask[i], 1'b0);
            checks++; if (bus.locked !== (i < LOSS_WIN - 1)) begin errors++; $display("FAIL edge_locked bit %0d: got %0b want %0b", i, bus.locked, i < LOSS_WIN - 1); end
        end
        $display("test_loss_at_window_end done: locked=%0b", bus.locked);
    endtask

    task automatic test_all_zero();
        hard_reset();
        for (int n = 0; n < 10000; n++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL zero_locked bit %0d: got %0b want 0", n, bus.locked); end
        end
        checks++; if (bus.bit_count !== 32'd0) begin errors++; $display("FAIL zero_bits: got %0d want 0", bus.bit_count); end
        $display("test_all_zero done");
    endtask

    task automatic test_valid_toggle_reset();
        int nv;
        hard_reset();
        gen_state = 16'hACE1;
        nv = 0;
        for (int k = 0; nv < 70 && k < 1000; k++) begin
            if (k % 3 == 0) begin drive(1'b1, gen_next(), 1'b0); nv++; end
            else drive(1'b0, 1'($urandom), 1'b0);
            checks++; if (bus.locked !== m_locked) begin errors++; $display("FAIL toggle_locked cyc %0d: got %0b want %0b", k, bus.locked, m_locked); end
        end
        checks++; if (bus.bit_count !== m_bc[31:0]) begin errors++; $display("FAIL toggle_bits: got %0d want %0d", bus.bit_count, m_bc); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL async_locked: got %0b want 0", bus.locked); end
        checks++; if (bus.bit_count !== 32'd0) begin errors++; $display("FAIL async_bits: got %0d want 0", bus.bit_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        nv = 0;
        for (int k = 0; nv < 30 && k < 200; k++) begin
            if (k % 3 == 0) begin drive(1'b1, gen_next(), 1'b0); nv++; end
            else drive(1'b0, 1'($urandom), 1'b0);
        end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL verify_rst_locked: got %0b want 0", bus.locked); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        nv = 0;
        for (int k = 0; nv < 48 && k < 500; k++) begin
            if (k % 3 == 0) begin drive(1'b1, gen_next(), 1'b0); nv++; end
            else drive(1'b0, 1'($urandom), 1'b0);
            checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL toggle_early cyc %0d: got %0b want 0", k, bus.locked); end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL toggle_relock: got %0b want 1", bus.locked); end
        for (int k = 0; k < 9; k++) drive(k % 3 == 0, gen_next(), 1'b0);
        checks++; if (bus.bit_count !== 32'd3) begin errors++; $display("FAIL toggle_bits2: got %0d want 3", bus.bit_count); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (bus.bit_count !== 32'd0) begin errors++; $display("FAIL clear_bits: got %0d want 0", bus.bit_count); end
        checks++; if (bus.err_count !== 32'd0) begin errors++; $display("FAIL clear_errs: got %0d want 0", bus.err_count); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL clear_locked: got %0b want 1", bus.locked); end
        $display("test_valid_toggle_reset done");
    endtask

    task automatic test_random();
        bit v, b, c;
        for (int k = 0; k < 4000; k++) begin
            v = ($urandom_range(3, 0) != 0);
            c = ($urandom_range(255, 0) == 0);
            b = v ? (gen_next() ^ ($urandom_range(63, 0) == 0)) : 1'($urandom);
            drive(v, b, c);
            checks++; if (bus.locked !== m_locked) begin errors++; $display("FAIL rnd_locked cyc %0d: got %0b want %0b", k, bus.locked, m_locked); end
            checks++; if (bus.err_pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse cyc %0d: got %0b want %0b", k, bus.err_pulse, m_pulse); end
            checks++; if (bus.bit_count !== m_bc[31:0]) begin errors++; $display("FAIL rnd_bits cyc %0d: got %0d want %0d", k, bus.bit_count, m_bc); end
            checks++; if (bus.err_count !== m_ec[31:0]) begin errors++; $display("FAIL rnd_errs cyc %0d: got %0d want %0d", k, bus.err_count, m_ec); end
        end
        $display("test_random done: bits=%0d errs=%0d", bus.bit_count, bus.err_count);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst_loss();
        test_two_windows();
        test_loss_at_window_end();
        test_all_zero();
        test_valid_toggle_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
